// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding,
// word-length codes and default oversampling parameters.
package uart_pkg;

   localparam int OSR_DEFAULT = 16;
   localparam int MID_DEFAULT = 7;

   localparam logic [1:0] WLEN_5 = 2'b00;
   localparam logic [1:0] WLEN_6 = 2'b01;
   localparam logic [1:0] WLEN_7 = 2'b10;
   localparam logic [1:0] WLEN_8 = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   // Index of the last data bit for a given word-length code.
   function automatic logic [2:0] last_bit_idx(input logic [1:0] wl);
      case (wl)
         WLEN_5:  return 3'd4;
         WLEN_6:  return 3'd5;
         WLEN_7:  return 3'd6;
         WLEN_8:  return 3'd7;
         default: return 3'd7;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops
// reset high so that an idle line produces no spurious falling edge
// when reset is released.
module uart_rx_sync (
   input  logic uart_clk_i,
   input  logic uart_rst_n_i,
   input  logic line_async,
   output logic line_sync
);

   logic line_meta;

   // Shift the raw line through two flops.
   always_ff @(posedge uart_clk_i or negedge uart_rst_n_i) begin
      if (!uart_rst_n_i) begin
         line_meta <= 1'b1;
         line_sync <= 1'b1;
      end else begin
         line_meta <= line_async;
         line_sync <= line_meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop decoding with
// per-frame configuration latch and one-cycle FIFO write/error strobes.
// Optional build macro UART_RX_MAJORITY_EN: decide each bit by a 2-of-3
// vote over ticks MID, MID+1, MID+2 instead of a single sample at MID.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a falling edge on the synchronized line
// ST_START  | validating the start bit; false start returns to idle
// ST_DATA   | sampling data bits LSB-first
// ST_PARITY | sampling and checking the parity bit
// ST_STOP   | sampling stop bit(s); last sample writes or flags overrun
module uart_rx #(
   parameter int OSR = uart_pkg::OSR_DEFAULT,
   parameter int MID = uart_pkg::MID_DEFAULT
) (
   input  logic       uart_clk_i,
   input  logic       uart_rst_n_i,
   input  logic       rx_clk_en_i,
   input  logic       uart_rx_i,
   input  logic [1:0] word_len_i,
   input  logic       parity_en_i,
   input  logic       even_parity_sel_i,
   input  logic       stp_bits_i,
   input  logic       rx_fifo_full_i,
   output logic [7:0] rx_fifo_data_o,
   output logic       rx_fifo_wr_en_o,
   output logic       parity_err_o,
   output logic       frame_err_o,
   output logic       overrun_err_o,
   output logic       rx_busy_o
);

   import uart_pkg::*;

   localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
`ifdef UART_RX_MAJORITY_EN
   localparam int DEC = MID + 2;
`else
   localparam int DEC = MID;
`endif
   localparam logic [CW-1:0] CNT_DEC  = CW'(DEC);
   localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);

   rx_state_e   state, state_nxt;
   logic        rx_s, rx_prev, fall;
   logic [CW-1:0] cnt;
   logic        tick_sample, tick_last, bit_val, last_data, finish;
   logic [1:0]  wlen_q;
   logic        par_en_q, even_q, stp2_q;
   logic [2:0]  bit_idx;
   logic        stop_idx;
   logic [7:0]  sr;
   logic        par_acc, par_err_q, frm_err_q;

   uart_rx_sync u_sync (
      .uart_clk_i   (uart_clk_i),
      .uart_rst_n_i (uart_rst_n_i),
      .line_async   (uart_rx_i),
      .line_sync    (rx_s)
   );

   assign fall        = rx_prev & ~rx_s;
   assign tick_sample = rx_clk_en_i && (cnt == CNT_DEC);
   assign tick_last   = rx_clk_en_i && (cnt == CNT_LAST);
   assign last_data   = (bit_idx == last_bit_idx(wlen_q));
   assign rx_busy_o   = (state != ST_IDLE);

`ifdef UART_RX_MAJORITY_EN
   localparam logic [CW-1:0] CNT_MID  = CW'(MID);
   localparam logic [CW-1:0] CNT_MID1 = CW'(MID + 1);
   logic s_mid, s_mid1;

   // Hold the first two of the three votes until the deciding tick.
   always_ff @(posedge uart_clk_i or negedge uart_rst_n_i) begin
      if (!uart_rst_n_i) begin
         s_mid  <= 1'b1;
         s_mid1 <= 1'b1;
      end else if (rx_clk_en_i) begin
         if (cnt == CNT_MID)  s_mid  <= rx_s;
         if (cnt == CNT_MID1) s_mid1 <= rx_s;
      end
   end

   assign bit_val = (s_mid & s_mid1) | (s_mid & rx_s) | (s_mid1 & rx_s);
`else
   assign bit_val = rx_s;
`endif

   // State register plus previous line value for edge detection.
   always_ff @(posedge uart_clk_i or negedge uart_rst_n_i) begin
      if (!uart_rst_n_i) begin
         state   <= ST_IDLE;
         rx_prev <= 1'b1;
      end else begin
         state   <= state_nxt;
         rx_prev <= rx_s;
      end
   end

   // Next-state decode; the start bit runs to its end so data bits
   // are sampled from bit-aligned counter positions.
   always_comb begin
      state_nxt = state;
      finish    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (fall) state_nxt = ST_START;
         end
         ST_START: begin
            if (tick_sample && bit_val) state_nxt = ST_IDLE;
            else if (tick_last)         state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (tick_last && last_data)
               state_nxt = par_en_q ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: begin
            if (tick_last) state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (tick_sample && (stop_idx == stp2_q)) begin
               finish    = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Oversampling tick counter; parked at zero while idle.
   always_ff @(posedge uart_clk_i or negedge uart_rst_n_i) begin
      if (!uart_rst_n_i)          cnt <= '0;
      else if (state == ST_IDLE)  cnt <= '0;
      else if (rx_clk_en_i)       cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
   end

   // Frame datapath: config latch, data capture, parity and stop checks.
   always_ff @(posedge uart_clk_i or negedge uart_rst_n_i) begin
      if (!uart_rst_n_i) begin
         wlen_q    <= WLEN_8;
         par_en_q  <= 1'b0;
         even_q    <= 1'b0;
         stp2_q    <= 1'b0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         sr        <= '0;
         par_acc   <= 1'b0;
         par_err_q <= 1'b0;
         frm_err_q <= 1'b0;
      end else if (state == ST_IDLE) begin
         if (fall) begin
            wlen_q    <= word_len_i;
            par_en_q  <= parity_en_i;
            even_q    <= even_parity_sel_i;
            stp2_q    <= stp_bits_i;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            sr        <= '0;
            par_acc   <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
         end
      end else begin
         case (state)
            ST_DATA: begin
               if (tick_sample) begin
                  sr[bit_idx] <= bit_val;
                  par_acc     <= par_acc ^ bit_val;
               end
               if (tick_last) bit_idx <= bit_idx + 3'd1;
            end
            ST_PARITY: begin
               if (tick_sample) par_err_q <= ((par_acc ^ bit_val) != ~even_q);
            end
            ST_STOP: begin
               if (tick_sample && !bit_val) frm_err_q <= 1'b1;
               if (tick_last)               stop_idx  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Registered FIFO write and error strobes, one cycle after the final
   // stop sample; a full FIFO turns the whole result into an overrun.
   always_ff @(posedge uart_clk_i or negedge uart_rst_n_i) begin
      if (!uart_rst_n_i) begin
         rx_fifo_data_o  <= '0;
         rx_fifo_wr_en_o <= 1'b0;
         parity_err_o    <= 1'b0;
         frame_err_o     <= 1'b0;
         overrun_err_o   <= 1'b0;
      end else begin
         rx_fifo_wr_en_o <= 1'b0;
         parity_err_o    <= 1'b0;
         frame_err_o     <= 1'b0;
         overrun_err_o   <= 1'b0;
         if (finish) begin
            if (!rx_fifo_full_i) begin
               rx_fifo_wr_en_o <= 1'b1;
               rx_fifo_data_o  <= sr;
               parity_err_o    <= par_err_q;
               frame_err_o     <= frm_err_q | ~bit_val;
            end else begin
               overrun_err_o   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames, false start, reset
// mid-frame, randomized frames and back-to-back frames against a
// frame-level reference model.
module tb_uart_rx;

   localparam int OSR     = 16;
   localparam int MID     = 7;
   localparam int DIV     = 4;
   localparam int BIT_CYC = OSR * DIV;

   logic       uart_clk_i = 1'b0;
   logic       uart_rst_n_i;
   logic       rx_clk_en_i;
   logic       uart_rx_i;
   logic [1:0] word_len_i;
   logic       parity_en_i, even_parity_sel_i, stp_bits_i, rx_fifo_full_i;
   logic [7:0] rx_fifo_data_o;
   logic       rx_fifo_wr_en_o, parity_err_o, frame_err_o, overrun_err_o, rx_busy_o;

   typedef struct packed {
      logic       wr;
      logic [7:0] data;
      logic       pe;
      logic       fe;
      logic       ov;
   } ev_t;

   typedef struct {
      logic [7:0] d;
      logic [1:0] wl;
      logic       pen, ev, s2, par_inv, stop_low, full, hold_low;
   } case_t;

   ev_t        evq[$];
   ev_t        expq[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] model_data;

   uart_rx #(.OSR(OSR), .MID(MID)) dut (
      .uart_clk_i        (uart_clk_i),
      .uart_rst_n_i      (uart_rst_n_i),
      .rx_clk_en_i       (rx_clk_en_i),
      .uart_rx_i         (uart_rx_i),
      .word_len_i        (word_len_i),
      .parity_en_i       (parity_en_i),
      .even_parity_sel_i (even_parity_sel_i),
      .stp_bits_i        (stp_bits_i),
      .rx_fifo_full_i    (rx_fifo_full_i),
      .rx_fifo_data_o    (rx_fifo_data_o),
      .rx_fifo_wr_en_o   (rx_fifo_wr_en_o),
      .parity_err_o      (parity_err_o),
      .frame_err_o       (frame_err_o),
      .overrun_err_o     (overrun_err_o),
      .rx_busy_o         (rx_busy_o)
   );

   always #5 uart_clk_i = ~uart_clk_i;

   // Baud tick: one-cycle enable every DIV clocks.
   initial begin
      rx_clk_en_i = 1'b0;
      forever begin
         repeat (DIV - 1) @(negedge uart_clk_i);
         rx_clk_en_i = 1'b1;
         @(negedge uart_clk_i);
         rx_clk_en_i = 1'b0;
      end
   end

   // Record every cycle carrying any strobe.
   always @(negedge uart_clk_i) begin
      if (rx_fifo_wr_en_o | parity_err_o | frame_err_o | overrun_err_o)
         evq.push_back({rx_fifo_wr_en_o, rx_fifo_data_o, parity_err_o, frame_err_o, overrun_err_o});
   end

   // Frame-level reference: what one transmitted frame should produce.
   function automatic ev_t model_frame(input logic [7:0] d, input logic [1:0] wl,
                                       input logic pen, input logic par_inv,
                                       input logic stop_low, input logic full,
                                       input logic [7:0] held);
      ev_t e;
      int  nb;
      nb = int'(wl) + 5;
      if (full) begin
         e = '{wr: 1'b0, data: held, pe: 1'b0, fe: 1'b0, ov: 1'b1};
      end else begin
         e.wr   = 1'b1;
         e.data = 8'(int'(d) & ((1 << nb) - 1));
         e.pe   = pen & par_inv;
         e.fe   = stop_low;
         e.ov   = 1'b0;
      end
      return e;
   endfunction

   task automatic drive_bit(input logic b);
      uart_rx_i = b;
      repeat (BIT_CYC) @(negedge uart_clk_i);
   endtask

   task automatic idle_bits(input int n, input logic lvl);
      uart_rx_i = lvl;
      repeat (n * BIT_CYC) @(negedge uart_clk_i);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [1:0] wl, input logic pen,
                             input logic ev, input logic s2, input logic par_inv,
                             input logic stop_low, input logic full, input logic scramble);
      int         nb;
      logic [7:0] dm;
      logic       p;
      nb = int'(wl) + 5;
      dm = 8'(int'(d) & ((1 << nb) - 1));
      p  = ev ? (^dm) : ~(^dm);
      word_len_i = wl; parity_en_i = pen; even_parity_sel_i = ev; stp_bits_i = s2;
      rx_fifo_full_i = full;
      drive_bit(1'b0);
      if (scramble) begin
         word_len_i        = 2'($urandom);
         parity_en_i       = 1'($urandom);
         even_parity_sel_i = 1'($urandom);
         stp_bits_i        = 1'($urandom);
      end
      for (int i = 0; i < nb; i++) drive_bit(d[i]);
      if (pen) drive_bit(p ^ par_inv);
      if (s2) drive_bit(1'b1);
      drive_bit(~stop_low);
      rx_fifo_full_i = 1'b0;
   endtask

   task automatic test_reset();
      uart_rst_n_i = 1'b0; uart_rx_i = 1'b1;
      word_len_i = 2'b11; parity_en_i = 1'b0; even_parity_sel_i = 1'b0;
      stp_bits_i = 1'b0; rx_fifo_full_i = 1'b0;
      model_data = 8'h00;
      repeat (5) @(negedge uart_clk_i);
      checks++; if (rx_fifo_data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_fifo_data_o); end
      checks++; if (rx_fifo_wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_wr got %b exp 0", rx_fifo_wr_en_o); end
      checks++; if ({parity_err_o, frame_err_o, overrun_err_o} !== 3'b000) begin errors++; $display("FAIL reset_err got %b exp 000", {parity_err_o, frame_err_o, overrun_err_o}); end
      checks++; if (rx_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", rx_busy_o); end
      uart_rst_n_i = 1'b1;
      idle_bits(1, 1'b1);
      checks++; if (rx_busy_o !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b exp 0", rx_busy_o); end
      checks++; if (evq.size() != 0) begin errors++; $display("FAIL post_reset_events got %0d exp 0", evq.size()); end
   endtask

   task automatic test_directed();
      case_t tbl[6];
      ev_t   e, g;
      tbl[0] = '{d: 8'h23, wl: 2'b11, pen: 0, ev: 0, s2: 0, par_inv: 0, stop_low: 0, full: 0, hold_low: 0};
      tbl[1] = '{d: 8'h23, wl: 2'b10, pen: 1, ev: 0, s2: 0, par_inv: 0, stop_low: 0, full: 0, hold_low: 0};
      tbl[2] = '{d: 8'h23, wl: 2'b10, pen: 1, ev: 0, s2: 0, par_inv: 1, stop_low: 0, full: 0, hold_low: 0};
      tbl[3] = '{d: 8'h5A, wl: 2'b11, pen: 0, ev: 0, s2: 1, par_inv: 0, stop_low: 1, full: 0, hold_low: 1};
      tbl[4] = '{d: 8'h23, wl: 2'b11, pen: 0, ev: 0, s2: 0, par_inv: 0, stop_low: 0, full: 1, hold_low: 0};
      tbl[5] = '{d: 8'h3C, wl: 2'b00, pen: 1, ev: 1, s2: 0, par_inv: 0, stop_low: 0, full: 0, hold_low: 0};
      for (int k = 0; k < 6; k++) begin
         evq.delete();
         e = model_frame(tbl[k].d, tbl[k].wl, tbl[k].pen, tbl[k].par_inv,
                         tbl[k].stop_low, tbl[k].full, model_data);
         if (e.wr) model_data = e.data;
         send_frame(tbl[k].d, tbl[k].wl, tbl[k].pen, tbl[k].ev, tbl[k].s2,
                    tbl[k].par_inv, tbl[k].stop_low, tbl[k].full, 1'b0);
         if (tbl[k].hold_low) begin
            idle_bits(4, 1'b0);
            checks++; if (rx_busy_o !== 1'b0) begin errors++; $display("FAIL case%0d_held_low_busy got %b exp 0", k, rx_busy_o); end
         end
         idle_bits(2, 1'b1);
         checks++;
         if (evq.size() != 1) begin
            errors++; $display("FAIL case%0d_event_count got %0d exp 1", k, evq.size());
         end else begin
            g = evq.pop_front();
            checks++;
            if (g !== e) begin
               errors++;
               $display("FAIL case%0d_event got wr=%b data=%h pe=%b fe=%b ov=%b exp wr=%b data=%h pe=%b fe=%b ov=%b",
                        k, g.wr, g.data, g.pe, g.fe, g.ov, e.wr, e.data, e.pe, e.fe, e.ov);
            end
         end
         checks++; if (rx_fifo_data_o !== model_data) begin errors++; $display("FAIL case%0d_data_hold got %h exp %h", k, rx_fifo_data_o, model_data); end
      end
   endtask

   task automatic test_false_start();
      evq.delete();
      uart_rx_i = 1'b0;
      repeat (4 * DIV) @(negedge uart_clk_i);
      checks++; if (rx_busy_o !== 1'b1) begin errors++; $display("FAIL glitch_busy got %b exp 1", rx_busy_o); end
      idle_bits(2, 1'b1);
      checks++; if (rx_busy_o !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b exp 0", rx_busy_o); end
      checks++; if (evq.size() != 0) begin errors++; $display("FAIL glitch_events got %0d exp 0", evq.size()); end
   endtask

   task automatic test_reset_mid_frame();
      ev_t g;
      evq.delete();
      word_len_i = 2'b11; parity_en_i = 1'b0; even_parity_sel_i = 1'b0; stp_bits_i = 1'b0;
      drive_bit(1'b0);
      drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
      uart_rst_n_i = 1'b0; uart_rx_i = 1'b1;
      @(negedge uart_clk_i);
      model_data = 8'h00;
      checks++; if (rx_busy_o !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b exp 0", rx_busy_o); end
      checks++; if (rx_fifo_data_o !== 8'h00) begin errors++; $display("FAIL midreset_data got %h exp 00", rx_fifo_data_o); end
      repeat (3) @(negedge uart_clk_i);
      uart_rst_n_i = 1'b1;
      idle_bits(2, 1'b1);
      checks++; if (evq.size() != 0) begin errors++; $display("FAIL midreset_partial got %0d events exp 0", evq.size()); end
      evq.delete();
      send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_bits(2, 1'b1);
      checks++;
      if (evq.size() != 1) begin
         errors++; $display("FAIL midreset_a5_count got %0d exp 1", evq.size());
      end else begin
         g = evq.pop_front();
         checks++;
         if (g !== {1'b1, 8'hA5, 3'b000}) begin
            errors++; $display("FAIL midreset_a5 got wr=%b data=%h pe=%b fe=%b ov=%b exp wr=1 data=a5 pe=0 fe=0 ov=0",
                               g.wr, g.data, g.pe, g.fe, g.ov);
         end
      end
      model_data = 8'hA5;
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic [1:0] wl;
      logic       pen, ev, s2, pinv, slow, full;
      ev_t        e, g;
      evq.delete(); expq.delete();
      for (int n = 0; n < 16; n++) begin
         d = 8'($urandom); wl = 2'($urandom); pen = 1'($urandom); ev = 1'($urandom);
         s2 = 1'($urandom);
         pinv = pen & ($urandom_range(0, 2) == 0);
         slow = ($urandom_range(0, 3) == 0);
         full = ($urandom_range(0, 4) == 0);
         e = model_frame(d, wl, pen, pinv, slow, full, model_data);
         if (e.wr) model_data = e.data;
         expq.push_back(e);
         send_frame(d, wl, pen, ev, s2, pinv, slow, full, 1'b1);
         idle_bits(1, 1'b1);
         repeat ($urandom_range(0, 40)) @(negedge uart_clk_i);
      end
      checks++; if (evq.size() != expq.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", evq.size(), expq.size()); end
      for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
         g = evq[i]; e = expq[i];
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL rand%0d got wr=%b data=%h pe=%b fe=%b ov=%b exp wr=%b data=%h pe=%b fe=%b ov=%b",
                     i, g.wr, g.data, g.pe, g.fe, g.ov, e.wr, e.data, e.pe, e.fe, e.ov);
         end
      end
      checks++; if (rx_fifo_data_o !== model_data) begin errors++; $display("FAIL rand_data_hold got %h exp %h", rx_fifo_data_o, model_data); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      logic [1:0] wl;
      logic       pen, ev, s2;
      ev_t        e, g;
      evq.delete(); expq.delete();
      for (int n = 0; n < 5; n++) begin
         d = 8'($urandom); wl = 2'($urandom); pen = 1'($urandom); ev = 1'($urandom);
         s2 = 1'($urandom);
         e = model_frame(d, wl, pen, 1'b0, 1'b0, 1'b0, model_data);
         model_data = e.data;
         expq.push_back(e);
         send_frame(d, wl, pen, ev, s2, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      idle_bits(2, 1'b1);
      checks++; if (evq.size() != expq.size()) begin errors++; $display("FAIL b2b_count got %0d exp %0d", evq.size(), expq.size()); end
      for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
         g = evq[i]; e = expq[i];
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL b2b%0d got wr=%b data=%h pe=%b fe=%b ov=%b exp wr=%b data=%h pe=%b fe=%b ov=%b",
                     i, g.wr, g.data, g.pe, g.fe, g.ov, e.wr, e.data, e.pe, e.fe, e.ov);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_false_start();
      test_reset_mid_frame();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
